// File: rtl/xor_if_pkg.sv
// Shared definitions for the two-operand XOR en/rdy initiator.
// State encoding, default widths and the saturating-increment helper.
package xor_if_pkg;

  localparam int DATA_W_DEF = 1;
  localparam int CNT_W_DEF  = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Increment v, sticking at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] max;
    max = (w >= 32) ? 32'hffff_ffff
                    : ((32'd1 << w) - 32'd1);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/xor_pair_initiator_fifo.sv
// Synchronous FIFO with wrap-bit pointers and an occupancy count.
// DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q, wp_d;
  logic [AW:0]      rp_q, rp_d;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (push) wp_d = wp_q + (AW+1)'(1);
    if (pop)  rp_d = rp_q + (AW+1)'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wp_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rp_q[AW-1:0]];
  assign count = wp_q - rp_q;
  assign empty = (wp_q == rp_q);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/xor_pair_initiator.sv
// Drives operand pairs onto the A/B channels and checks Y against A^B.
// Define XOR_PAIR_INITIATOR_TMO_EN to build the watchdog and tmo port.
module xor_pair_initiator
  import xor_if_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CMD_DEPTH = 4,
  parameter int EXP_DEPTH = 4,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int TMO_W     = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       cmd_valid,
  input  logic [DATA_W-1:0]          cmd_a,
  input  logic [DATA_W-1:0]          cmd_b,
  output logic                       cmd_rdy,
  output logic [DATA_W-1:0]          a_data,
  output logic                       a_en,
  input  logic                       a_rdy,
  output logic [DATA_W-1:0]          b_data,
  output logic                       b_en,
  input  logic                       b_rdy,
  input  logic [DATA_W-1:0]          y_data,
  input  logic                       y_en,
  output logic                       y_rdy,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           fail_cnt,
  output logic [$clog2(EXP_DEPTH):0] outstanding,
  output logic                       err,
  output logic                       idle
`ifdef XOR_PAIR_INITIATOR_TMO_EN
  ,
  output logic                       tmo
`endif
);

  localparam int OW = $clog2(EXP_DEPTH) + 1;

  logic [1:0]          state_q, state_d;
  logic                a_en_q, a_en_d;
  logic                b_en_q, b_en_d;
  logic [DATA_W-1:0]   a_data_q, a_data_d;
  logic [DATA_W-1:0]   b_data_q, b_data_d;
  logic                y_rdy_q, y_rdy_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    pass_q, pass_d;
  logic [CNT_W-1:0]    fail_q, fail_d;

  logic                cmd_push, cmd_pop;
  logic                cmd_full, cmd_empty;
  logic [2*DATA_W-1:0] cmd_head;
  logic [$clog2(CMD_DEPTH):0] unused_cmd_cnt;

  logic                exp_push, exp_pop;
  logic                exp_full, exp_empty;
  logic [DATA_W-1:0]   exp_head, exp_wdata;
  logic [OW-1:0]       exp_cnt;

  logic                can_issue, y_xfer;

  assign cmd_rdy   = !cmd_full;
  assign cmd_push  = cmd_valid && !cmd_full;
  assign can_issue = !cmd_empty && !exp_full;
  assign y_xfer    = y_en && y_rdy_q;
  assign exp_pop   = y_xfer;
  assign exp_wdata = cmd_head[2*DATA_W-1:DATA_W]
                   ^ cmd_head[DATA_W-1:0];

  sync_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (cmd_push),
    .pop   (cmd_pop),
    .wdata ({cmd_a, cmd_b}),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (unused_cmd_cnt)
  );

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (EXP_DEPTH)
  ) u_exp_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (exp_push),
    .pop   (exp_pop),
    .wdata (exp_wdata),
    .rdata (exp_head),
    .full  (exp_full),
    .empty (exp_empty),
    .count (exp_cnt)
  );

  // ISSUE leaves only once both en flops read low, so the
  // pair period is never shorter than three cycles.
  always_comb begin
    state_d  = state_q;
    a_en_d   = a_en_q;
    b_en_d   = b_en_q;
    a_data_d = a_data_q;
    b_data_d = b_data_q;
    cmd_pop  = 1'b0;
    exp_push = 1'b0;
    unique case (state_q)
      ST_ISSUE: begin
        a_en_d = a_en_q && !a_rdy;
        b_en_d = b_en_q && !b_rdy;
        if (!a_en_q && !b_en_q) state_d = ST_HOLD;
      end
      default: begin
        state_d = ST_IDLE;
        if (can_issue) begin
          state_d  = ST_ISSUE;
          cmd_pop  = 1'b1;
          exp_push = 1'b1;
          a_en_d   = 1'b1;
          b_en_d   = 1'b1;
          a_data_d = cmd_head[2*DATA_W-1:DATA_W];
          b_data_d = cmd_head[DATA_W-1:0];
        end
      end
    endcase
  end

  always_comb begin
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;
    y_rdy_d = exp_push || (exp_cnt > OW'(exp_pop));
    if (y_xfer) begin
      if (y_data == exp_head) begin
        pass_d = CNT_W'(sat_inc(32'(pass_q), CNT_W));
      end else begin
        fail_d = CNT_W'(sat_inc(32'(fail_q), CNT_W));
        err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      a_en_q   <= 1'b0;
      b_en_q   <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
      y_rdy_q  <= 1'b0;
      err_q    <= 1'b0;
      pass_q   <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_en_q   <= a_en_d;
      b_en_q   <= b_en_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      y_rdy_q  <= y_rdy_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  assign a_en        = a_en_q;
  assign b_en        = b_en_q;
  assign a_data      = a_data_q;
  assign b_data      = b_data_q;
  assign y_rdy       = y_rdy_q;
  assign err         = err_q;
  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
  assign outstanding = exp_cnt;
  assign idle        = cmd_empty && (state_q == ST_IDLE)
                    && exp_empty;

`ifdef XOR_PAIR_INITIATOR_TMO_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_q, tmo_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = tmo_q;
    if (y_xfer || exp_empty) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != '1) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
    if (tmo_cnt_d == '1) tmo_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign tmo = tmo_q;
`else
  logic unused_tmo_w;
  assign unused_tmo_w = (TMO_W > 0);
`endif

endmodule

// File: tb/tb_xor_pair_initiator.sv
// Directed and random stimulus for xor_pair_initiator, checked
// against a queue-based model of pairs, expected results and counts.
module tb_xor_pair_initiator;

  localparam int DW   = 4;
  localparam int CD   = 4;
  localparam int ED   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK, RST_N;
  logic          cmd_valid, cmd_rdy;
  logic [DW-1:0] cmd_a, cmd_b;
  logic [DW-1:0] a_data, b_data, y_data;
  logic          a_en, a_rdy, b_en, b_rdy;
  logic          y_en, y_rdy, err, idle;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic [$clog2(ED):0] outstanding;

  xor_pair_initiator #(
    .DATA_W    (DW),
    .CMD_DEPTH (CD),
    .EXP_DEPTH (ED),
    .CNT_W     (CW),
    .TMO_W     (8)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .cmd_valid   (cmd_valid),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_rdy     (cmd_rdy),
    .a_data      (a_data),
    .a_en        (a_en),
    .a_rdy       (a_rdy),
    .b_data      (b_data),
    .b_en        (b_en),
    .b_rdy       (b_rdy),
    .y_data      (y_data),
    .y_en        (y_en),
    .y_rdy       (y_rdy),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt),
    .outstanding (outstanding),
    .err         (err),
    .idle        (idle)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          bad;
  } pair_t;

  pair_t         to_send[$];
  pair_t         cmdq[$];
  logic [DW-1:0] expq[$];
  logic [DW-1:0] respq[$];

  int   n_vec = 0;
  int   n_bad = 0;
  int   pass_m, fail_m, cyc_n, last_iss;
  logic err_m, a_pend, b_pend, prev_en, have_iss;
  logic [DW-1:0] cur_a, cur_b;
  int   a_mode, b_mode;
  logic y_on, y_rand, y_spur, cmd_rand;
  logic p_cmd, p_a, p_b, p_y;
  logic [DW-1:0] p_yd;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic rdy_of(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic model_reset();
    to_send.delete();
    cmdq.delete();
    expq.delete();
    respq.delete();
    pass_m   = 0;
    fail_m   = 0;
    err_m    = 1'b0;
    a_pend   = 1'b0;
    b_pend   = 1'b0;
    cur_a    = '0;
    cur_b    = '0;
    prev_en  = 1'b0;
    have_iss = 1'b0;
  endtask

  task automatic push_pair(input logic [DW-1:0] a,
                           input logic [DW-1:0] b,
                           input logic bad);
    pair_t p;
    p.a = a;
    p.b = b;
    p.bad = bad;
    to_send.push_back(p);
  endtask

  task automatic cyc();
    int    n_pre;
    pair_t pr;
    logic [DW-1:0] e;
    cmd_valid = (to_send.size() > 0)
             && (!cmd_rand || $urandom_range(0, 3) != 0);
    if (to_send.size() > 0) begin
      cmd_a = to_send[0].a;
      cmd_b = to_send[0].b;
    end
    a_rdy  = rdy_of(a_mode);
    b_rdy  = rdy_of(b_mode);
    y_en   = y_spur || (y_on && respq.size() > 0
           && (!y_rand || $urandom_range(0, 2) != 0));
    y_data = (respq.size() > 0) ? respq[0] : DW'($urandom);
    p_cmd  = cmd_valid && cmd_rdy;
    p_a    = a_en && a_rdy;
    p_b    = b_en && b_rdy;
    p_y    = y_en && y_rdy;
    p_yd   = y_data;
    @(posedge CLK);
    @(negedge CLK);
    cyc_n++;
    if (p_cmd) cmdq.push_back(to_send.pop_front());
    if (p_a) a_pend = 1'b0;
    if (p_b) b_pend = 1'b0;
    n_pre = expq.size();
    if (p_y && expq.size() > 0) begin
      if (respq.size() > 0) void'(respq.pop_front());
      e = expq.pop_front();
      if (p_yd == e) begin
        pass_m = sat(pass_m);
      end else begin
        fail_m = sat(fail_m);
        err_m  = 1'b1;
      end
    end
    if (a_en && b_en && !prev_en) begin
      chk("issue_has_cmd", 32'(cmdq.size() > 0), 32'(1));
      chk("issue_exp_room", 32'(n_pre < ED), 32'(1));
      if (have_iss)
        chk("pair_period", 32'(cyc_n - last_iss >= 3), 32'(1));
      if (cmdq.size() > 0) begin
        pr = cmdq.pop_front();
        cur_a = pr.a;
        cur_b = pr.b;
        expq.push_back(pr.a ^ pr.b);
        respq.push_back(pr.a ^ pr.b ^ DW'(pr.bad));
      end
      have_iss = 1'b1;
      last_iss = cyc_n;
      a_pend   = 1'b1;
      b_pend   = 1'b1;
    end
    prev_en = a_en || b_en;
    chk("a_en", 32'(a_en), 32'(a_pend));
    chk("b_en", 32'(b_en), 32'(b_pend));
    chk("a_data", 32'(a_data), 32'(cur_a));
    chk("b_data", 32'(b_data), 32'(cur_b));
    chk("cmd_rdy", 32'(cmd_rdy), 32'(cmdq.size() < CD));
    chk("y_rdy", 32'(y_rdy), 32'(expq.size() > 0));
    chk("outstanding", 32'(outstanding), 32'(expq.size()));
    chk("pass_cnt", 32'(pass_cnt), 32'(pass_m));
    chk("fail_cnt", 32'(fail_cnt), 32'(fail_m));
    chk("err", 32'(err), 32'(err_m));
  endtask

  task automatic drain(input int budget);
    int   n;
    logic busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      cyc();
      n++;
      busy = (to_send.size() > 0) || (cmdq.size() > 0)
          || (expq.size() > 0) || a_pend || b_pend;
    end
    chk("drain_done", 32'(busy), 32'(0));
    repeat (3) cyc();
    chk("idle_after_drain", 32'(idle), 32'(1));
  endtask

  task automatic wait_issue(input string tag);
    int n;
    n = 0;
    while (!a_en && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, 32'(a_en), 32'(1));
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    y_en = 1'b0;
    y_data = '0;
    a_mode = 0;
    b_mode = 0;
    y_on = 1'b1;
    y_rand = 1'b0;
    y_spur = 1'b0;
    cmd_rand = 1'b0;
    cyc_n = 0;
    last_iss = 0;
    model_reset();
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_a_en", 32'(a_en), 32'(0));
    chk("rst_b_en", 32'(b_en), 32'(0));
    chk("rst_y_rdy", 32'(y_rdy), 32'(0));
    chk("rst_a_data", 32'(a_data), 32'(0));
    chk("rst_b_data", 32'(b_data), 32'(0));
    chk("rst_pass", 32'(pass_cnt), 32'(0));
    chk("rst_fail", 32'(fail_cnt), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_out", 32'(outstanding), 32'(0));
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'(1));
    chk("rst_idle", 32'(idle), 32'(1));
    RST_N = 1'b1;

    // single pair, responder always ready
    push_pair(DW'(1), DW'(0), 1'b0);
    cyc();
    chk("t1_en_at_push", 32'(a_en), 32'(0));
    cyc();
    chk("t1_en_next", 32'(a_en && b_en), 32'(1));
    chk("t1_a_data", 32'(a_data), 32'(1));
    drain(50);
    chk("t1_pass", 32'(pass_cnt), 32'(1));
    chk("t1_fail", 32'(fail_cnt), 32'(0));

    // skewed acceptance: A at cycle 2, B at cycle 5
    a_mode = 2;
    b_mode = 2;
    push_pair(DW'($urandom), DW'($urandom), 1'b0);
    push_pair(DW'($urandom), DW'($urandom), 1'b0);
    wait_issue("t2_issue");
    repeat (2) cyc();
    a_mode = 0;
    cyc();
    a_mode = 2;
    chk("t2_a_dropped", 32'(a_en), 32'(0));
    chk("t2_b_held", 32'(b_en), 32'(1));
    repeat (2) cyc();
    b_mode = 0;
    cyc();
    b_mode = 2;
    chk("t2_b_dropped", 32'(b_en), 32'(0));
    cyc();
    chk("t2_no_next_c6", 32'(a_en || b_en), 32'(0));
    a_mode = 0;
    b_mode = 0;
    drain(100);

    // back-to-back pairs
    push_pair(DW'(0), DW'(0), 1'b0);
    push_pair(DW'(0), DW'(1), 1'b0);
    push_pair(DW'(1), DW'(0), 1'b0);
    push_pair(DW'(1), DW'(1), 1'b0);
    drain(100);
    chk("t3_out_zero", 32'(outstanding), 32'(0));

    // mismatch then passing pairs
    push_pair(DW'(1), DW'(1), 1'b1);
    push_pair(DW'(2), DW'(3), 1'b0);
    push_pair(DW'(5), DW'(5), 1'b0);
    drain(100);
    chk("t4_err_sticky", 32'(err), 32'(1));
    chk("t4_fail", 32'(fail_cnt), 32'(1));

    // Y backpressure with 8 pairs
    y_on = 1'b0;
    for (int i = 0; i < 8; i++)
      push_pair(DW'($urandom), DW'($urandom), 1'b0);
    repeat (30) cyc();
    chk("t5_out_cap", 32'(outstanding), 32'(ED));
    chk("t5_cmd_full", 32'(cmd_rdy), 32'(0));
    chk("t5_all_taken", 32'(to_send.size()), 32'(0));
    chk("t5_not_idle", 32'(idle), 32'(0));
    y_on = 1'b1;
    drain(200);
    chk("t5_pass_sat", 32'(pass_cnt), 32'(CMAX));

    // y_en while y_rdy low is ignored
    y_spur = 1'b1;
    repeat (4) cyc();
    y_spur = 1'b0;
    cyc();

    // random traffic
    a_mode = 1;
    b_mode = 1;
    y_rand = 1'b1;
    cmd_rand = 1'b1;
    for (int i = 0; i < 60; i++)
      push_pair(DW'($urandom), DW'($urandom),
                1'($urandom_range(0, 7) == 0));
    drain(3000);
    a_mode = 0;
    b_mode = 0;
    y_rand = 1'b0;
    cmd_rand = 1'b0;

    // reset mid-ISSUE with two pairs queued
    a_mode = 2;
    b_mode = 2;
    for (int i = 0; i < 3; i++)
      push_pair(DW'($urandom), DW'($urandom), 1'b0);
    wait_issue("t6_issue");
    repeat (4) cyc();
    chk("t6_queued", 32'(to_send.size() + cmdq.size()), 32'(2));
    #2 RST_N = 1'b0;
    cmd_valid = 1'b0;
    y_en = 1'b0;
    #1;
    chk("t6_a_en", 32'(a_en), 32'(0));
    chk("t6_b_en", 32'(b_en), 32'(0));
    chk("t6_y_rdy", 32'(y_rdy), 32'(0));
    chk("t6_pass", 32'(pass_cnt), 32'(0));
    chk("t6_fail", 32'(fail_cnt), 32'(0));
    chk("t6_err", 32'(err), 32'(0));
    chk("t6_out", 32'(outstanding), 32'(0));
    model_reset();
    a_mode = 0;
    b_mode = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) cyc();
    chk("t6_idle", 32'(idle), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
